reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 32, the register and port data width in bits.
REQ-002 The block SHALL expose parameter ADDR_W, default 5, the register address width, giving 2**ADDR_W registers.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port rs_addr, input, ADDR_W bits: read port A address.
REQ-007 The block SHALL have port rt_addr, input, ADDR_W bits: read port B address.
REQ-008 The block SHALL have port rd_addr, input, ADDR_W bits: write address.
REQ-009 The block SHALL have port wr_en, input, 1 bit: write enable.
REQ-010 The block SHALL have port wr_data, input, DATA_W bits: write data.
REQ-011 The block SHALL have port rs_data, output, DATA_W bits: read port A data, driving ALU operand a.
REQ-012 The block SHALL have port rt_data, output, DATA_W bits: read port B data, driving ALU operand b.
REQ-013 The block SHALL have port rs_eq_rt, output, 1 bit: 1 when rs_data equals rt_data, used for early branch compare.

Function
REQ-014 The block SHALL hold 2**ADDR_W registers of DATA_W bits each.
REQ-015 Reads SHALL be combinational with zero-cycle latency: rs_data = reg[rs_addr] and rt_data = reg[rt_addr].
REQ-016 On a rising edge with wr_en=1, rst=0 and rd_addr!=0, the block SHALL load wr_data into reg[rd_addr], visible on read ports from the next cycle.
REQ-017 Register 0 SHALL read 0 at all times; writes to address 0 SHALL be ignored.
REQ-018 When wr_en=0, register contents SHALL hold.
REQ-019 Both read ports addressing the same register SHALL return identical data.
REQ-020 rs_eq_rt SHALL be derived combinationally from the final rs_data and rt_data values, including any bypass result.
REQ-021 X or Z on rd_addr or wr_data while wr_en=0 SHALL NOT alter any register.
REQ-022 Outputs SHALL NOT be registered; the block SHALL add no pipeline stage between operand address and ALU operand.

Reset
REQ-023 On a rising edge with rst=1, all registers SHALL clear to 0, regardless of wr_en.
REQ-024 When rst=1 and wr_en=1 in the same cycle, reset SHALL win and the write SHALL be discarded.
REQ-025 While rst is held, rs_data, rt_data and rs_eq_rt SHALL be driven from the cleared contents (0, 0, 1) from the first post-edge cycle onward.
REQ-026 No asynchronous reset path SHALL exist; before the first reset edge, contents are undefined.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-028 With REGFILE_BYPASS_EN defined, when wr_en=1, rst=0, rd_addr!=0 and a read address equals rd_addr in the same cycle, that read port SHALL return wr_data combinationally.
REQ-029 Without REGFILE_BYPASS_EN, such a same-cycle read SHALL return the pre-write stored value, and the new value SHALL appear on the next cycle.
REQ-030 In both configurations, reads of address 0 SHALL return 0, and bypass SHALL NOT apply while rst=1.

Verification
REQ-031 The bench SHALL cover this case: rst=1 for 1 cycle, then read all 32 addresses -> every rs_data and rt_data equals 0x00000000 and rs_eq_rt=1.
REQ-032 The bench SHALL cover this case: write 0x00000001 to r1 and 0x00000003 to r2, then set rs_addr=2 and rt_addr=1 -> rs_data=0x00000003, rt_data=0x00000001, rs_eq_rt=0.
REQ-033 The bench SHALL cover this case: wr_en=1, rd_addr=0, wr_data=0xFFFFFFFF, then read r0 on both ports -> 0x00000000.
REQ-034 The bench SHALL cover this case: r5=0x0000AAAA stored, then in one cycle write r5=0x12345678 with rs_addr=5 -> rs_data=0x12345678 with REGFILE_BYPASS_EN and 0x0000AAAA without it; in the next cycle rs_data=0x12345678 in both builds.
REQ-035 The bench SHALL cover this case: rst=1 and wr_en=1 with rd_addr=7 and wr_data=0x55 in the same cycle -> r7 reads 0x00000000 afterwards.
REQ-036 The bench SHALL cover this case: r3 = r4 = 0x00000010 with rs_addr=3 and rt_addr=4 -> rs_eq_rt=1; then write r4=0x00000011 -> rs_eq_rt=0 on the next cycle.

Source files
------------

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
//
// Purpose:
//   Two-read / one-write general purpose register file. Register 0 is
//   hard-wired to zero. Reads are purely combinational so the read data can
//   feed the ALU operands in the same cycle the addresses are presented.
//   rs_eq_rt gives an early equality compare of the two read ports for
//   branch resolution.
//
// Configuration:
//   REGFILE_BYPASS_EN - when defined, a read port whose address matches an
//                       in-flight write (wr_en=1, rst=0, rd_addr!=0) returns
//                       wr_data in the same cycle. When undefined, such a
//                       read returns the stored (pre-write) value.
//
// Ports:
//   clk      in  1        clock, all state changes on rising edge
//   rst      in  1        synchronous active-high reset, clears all registers
//   rs_addr  in  ADDR_W   read port A address
//   rt_addr  in  ADDR_W   read port B address
//   rd_addr  in  ADDR_W   write address
//   wr_en    in  1        write enable
//   wr_data  in  DATA_W   write data
//   rs_data  out DATA_W   read port A data (ALU operand a)
//   rt_data  out DATA_W   read port B data (ALU operand b)
//   rs_eq_rt out 1        1 when rs_data == rt_data
// -----------------------------------------------------------------------------
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_eq_rt
);

  localparam int NREG = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  // Entry 0 is kept in the array (always zero) so indexed reads stay in range;
  // the read mux still forces zero for address 0 so it reads 0 even before
  // the first reset.
  logic [DATA_W-1:0] mem_r [0:NREG-1];

  logic              wr_fire_s;
  logic [DATA_W-1:0] rs_data_s;
  logic [DATA_W-1:0] rt_data_s;

  // A write that actually lands: reset wins, and address 0 is never written.
  assign wr_fire_s = wr_en & ~rst & (rd_addr != ADDR_ZERO);

  // Register storage: synchronous clear, otherwise gated write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_r[i] <= DATA_ZERO;
      end
    end else if (wr_fire_s) begin
      mem_r[rd_addr] <= wr_data;
    end
  end

  // Read port A: zero register, optional forwarding, else stored value.
  always_comb begin
    rs_data_s = DATA_ZERO;
    if (rs_addr == ADDR_ZERO) begin
      rs_data_s = DATA_ZERO;
`ifdef REGFILE_BYPASS_EN
    end else if (wr_fire_s && (rs_addr == rd_addr)) begin
      rs_data_s = wr_data;
`endif
    end else begin
      rs_data_s = mem_r[rs_addr];
    end
  end

  // Read port B: same selection as port A so equal addresses give equal data.
  always_comb begin
    rt_data_s = DATA_ZERO;
    if (rt_addr == ADDR_ZERO) begin
      rt_data_s = DATA_ZERO;
`ifdef REGFILE_BYPASS_EN
    end else if (wr_fire_s && (rt_addr == rd_addr)) begin
      rt_data_s = wr_data;
`endif
    end else begin
      rt_data_s = mem_r[rt_addr];
    end
  end

  // Compare is taken after forwarding so branch resolution sees final operands.
  assign rs_data  = rs_data_s;
  assign rt_data  = rt_data_s;
  assign rs_eq_rt = (rs_data_s == rt_data_s);

endmodule

// File: tb/tb_reg_file.sv
// -----------------------------------------------------------------------------
// tb_reg_file
//
// Directed self-checking bench for reg_file (DATA_W=32, ADDR_W=5).
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns later,
// well away from the next edge. Expectations for same-cycle reads depend on
// whether REGFILE_BYPASS_EN is defined for the build.
// -----------------------------------------------------------------------------
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  rd_addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        rs_eq_rt;

  int pass_cnt  = 0;
  int total_cnt = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rd_addr  (rd_addr),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .rs_eq_rt (rs_eq_rt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One write cycle, returns 1 ns after the capturing edge with wr_en low.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    rd_addr = a;
    wr_data = d;
    wr_en   = 1'b1;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    rs_addr = 5'd0;
    rt_addr = 5'd0;
    rd_addr = 5'd0;
    wr_data = 32'h0;

    // Reset for one cycle, then all addresses must read zero.
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rs_addr = a[4:0];
      rt_addr = a[4:0];
      #1;
      chk($sformatf("reset_rs[%0d]", a), rs_data, 32'h0);
      chk($sformatf("reset_rt[%0d]", a), rt_data, 32'h0);
      chk($sformatf("reset_eq[%0d]", a), {31'h0, rs_eq_rt}, 32'h1);
    end

    // Basic writes and two-port read.
    wr(5'd1, 32'h0000_0001);
    wr(5'd2, 32'h0000_0003);
    rs_addr = 5'd2;
    rt_addr = 5'd1;
    #1;
    chk("rd_r2_rs", rs_data, 32'h0000_0003);
    chk("rd_r1_rt", rt_data, 32'h0000_0001);
    chk("rd_neq",   {31'h0, rs_eq_rt}, 32'h0);

    // Write to r0 is ignored, also on the same cycle (no forwarding for r0).
    @(posedge clk);
    #1;
    rd_addr = 5'd0;
    wr_data = 32'hFFFF_FFFF;
    wr_en   = 1'b1;
    rs_addr = 5'd0;
    rt_addr = 5'd0;
    #1;
    chk("r0_same_cycle", rs_data, 32'h0);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    #1;
    chk("r0_rs", rs_data, 32'h0);
    chk("r0_rt", rt_data, 32'h0);
    chk("r0_eq", {31'h0, rs_eq_rt}, 32'h1);

    // Same-cycle write/read of r5.
    wr(5'd5, 32'h0000_AAAA);
    rs_addr = 5'd5;
    rt_addr = 5'd5;
    #1;
    chk("r5_old", rs_data, 32'h0000_AAAA);
    @(posedge clk);
    #1;
    rd_addr = 5'd5;
    wr_data = 32'h1234_5678;
    wr_en   = 1'b1;
    #1;
    chk("r5_same_rs", rs_data, BYPASS ? 32'h1234_5678 : 32'h0000_AAAA);
    chk("r5_same_rt", rt_data, BYPASS ? 32'h1234_5678 : 32'h0000_AAAA);
    chk("r5_same_eq", {31'h0, rs_eq_rt}, 32'h1);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    #1;
    chk("r5_next", rs_data, 32'h1234_5678);

    // Hold: X on write address/data with wr_en low changes nothing.
    rd_addr = 'x;
    wr_data = 'x;
    rs_addr = 5'd1;
    rt_addr = 5'd2;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("hold_r1", rs_data, 32'h0000_0001);
    chk("hold_r2", rt_data, 32'h0000_0003);

    // Reset and write in the same cycle: reset wins, no forwarding under reset.
    @(posedge clk);
    #1;
    rst     = 1'b1;
    wr_en   = 1'b1;
    rd_addr = 5'd7;
    wr_data = 32'h0000_0055;
    rs_addr = 5'd7;
    rt_addr = 5'd7;
    #1;
    chk("rst_wr_same_rs", rs_data, 32'h0);
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rs_addr = 5'd5;
    rt_addr = 5'd1;
    #1;
    chk("rst_held_rs", rs_data, 32'h0);
    chk("rst_held_rt", rt_data, 32'h0);
    chk("rst_held_eq", {31'h0, rs_eq_rt}, 32'h1);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    rs_addr = 5'd7;
    rt_addr = 5'd2;
    #1;
    chk("r7_after_rst", rs_data, 32'h0);
    chk("r2_after_rst", rt_data, 32'h0);

    // Early branch compare.
    wr(5'd3, 32'h0000_0010);
    wr(5'd4, 32'h0000_0010);
    rs_addr = 5'd3;
    rt_addr = 5'd4;
    #1;
    chk("eq_r3_r4", {31'h0, rs_eq_rt}, 32'h1);
    @(posedge clk);
    #1;
    rd_addr = 5'd4;
    wr_data = 32'h0000_0011;
    wr_en   = 1'b1;
    #1;
    chk("eq_same_cycle", {31'h0, rs_eq_rt}, BYPASS ? 32'h0 : 32'h1);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    #1;
    chk("eq_after_wr", {31'h0, rs_eq_rt}, 32'h0);
    chk("r4_new",      rt_data, 32'h0000_0011);
    chk("r3_kept",     rs_data, 32'h0000_0010);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
